// File: rtl/hostctrl_word_serializer.sv
// Streams buffered {address, data} words to host_ctrl one byte at a time over the
// valid/ack_data/next handshake, waiting for a per-word commit before the next word.
module hostctrl_word_serializer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int MSB_FIRST   = 0,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          wr_last_i,
  output logic [7:0]                    hostctrl_data,
  output logic                          hostctrl_valid,
  input  logic                          hostctrl_ack_data,
  output logic                          hostctrl_next,
  input  logic                          hostctrl_ack,
  output logic                          hostctrl_done,
  output logic                          err_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [31:0]                   words_sent_o
);

  // state    | meaning
  // S_IDLE   | waiting for a buffered word
  // S_ADDR_B | presenting address byte b, waiting for ack_data
  // S_ADDR_N | one-cycle next pulse after an address byte
  // S_DATA_B | presenting data byte b, waiting for ack_data
  // S_DATA_N | one-cycle next pulse after a data byte
  // S_COMMIT | waiting for host_ctrl to commit the whole word
  // S_DONE   | last word committed; sticky until reset
  // S_ERROR  | handshake timed out; sticky until reset

  localparam int NA = ADDR_WIDTH / 8;
  localparam int ND = DATA_WIDTH / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TLOAD = (ACK_TIMEOUT > 0) ? 32'(ACK_TIMEOUT - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_B, S_ADDR_N, S_DATA_B, S_DATA_N, S_COMMIT, S_DONE, S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_bidx;
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_level;
  logic [31:0]           r_words;
  logic [31:0]           r_tcnt;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_tc;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_head_last;
  int                    w_aidx;
  int                    w_didx;
  logic [7:0]            w_abyte;
  logic [7:0]            w_dbyte;

  // A full FIFO refuses pushes even on a popping edge: no pass-through path.
  assign w_full       = (int'(r_level) == FIFO_DEPTH);
  assign wr_ready_o   = !w_full && (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_push       = wr_valid_i && wr_ready_o;
  assign w_pop        = (r_state == S_COMMIT) && hostctrl_ack;
  assign w_tc         = (ACK_TIMEOUT > 0) && (r_tcnt == 32'd0);
  assign w_head_addr  = r_mem_addr[r_rptr];
  assign w_head_data  = r_mem_data[r_rptr];
  assign w_head_last  = r_mem_last[r_rptr];
  assign fifo_level_o = r_level;
  assign words_sent_o = r_words;

  always_comb begin
    w_abyte = 8'd0;
    w_dbyte = 8'd0;
    w_aidx  = (MSB_FIRST != 0) ? (NA - 1 - int'(r_bidx)) : int'(r_bidx);
    w_didx  = (MSB_FIRST != 0) ? (ND - 1 - int'(r_bidx)) : int'(r_bidx);
    for (int k = 0; k < NA; k++) begin
      if (k == w_aidx) w_abyte = w_head_addr[8*k +: 8];
    end
    for (int k = 0; k < ND; k++) begin
      if (k == w_didx) w_dbyte = w_head_data[8*k +: 8];
    end
  end

  always_comb begin
    w_next         = r_state;
    hostctrl_valid = 1'b0;
    hostctrl_next  = 1'b0;
    hostctrl_data  = 8'd0;
    hostctrl_done  = 1'b0;
    err_o          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) w_next = S_ADDR_B;
      end
      S_ADDR_B: begin
        hostctrl_valid = 1'b1;
        hostctrl_data  = w_abyte;
        if (hostctrl_ack_data) w_next = S_ADDR_N;
        else if (w_tc)         w_next = S_ERROR;
      end
      S_ADDR_N: begin
        hostctrl_next = 1'b1;
        hostctrl_data = w_abyte;
        w_next = (int'(r_bidx) == NA - 1) ? S_DATA_B : S_ADDR_B;
      end
      S_DATA_B: begin
        hostctrl_valid = 1'b1;
        hostctrl_data  = w_dbyte;
        if (hostctrl_ack_data) w_next = S_DATA_N;
        else if (w_tc)         w_next = S_ERROR;
      end
      S_DATA_N: begin
        hostctrl_next = 1'b1;
        hostctrl_data = w_dbyte;
        w_next = (int'(r_bidx) == ND - 1) ? S_COMMIT : S_DATA_B;
      end
      S_COMMIT: begin
        hostctrl_data = w_dbyte;
        if (hostctrl_ack) w_next = w_head_last ? S_DONE : S_IDLE;
        else if (w_tc)    w_next = S_ERROR;
      end
      S_DONE:  hostctrl_done = 1'b1;
      S_ERROR: err_o = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= wr_addr_i;
      r_mem_data[r_wptr] <= wr_data_i;
      r_mem_last[r_wptr] <= wr_last_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_bidx  <= 3'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_words <= 32'd0;
      r_tcnt  <= TLOAD;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_words <= r_words + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      case (r_state)
        S_ADDR_N: r_bidx <= (int'(r_bidx) == NA - 1) ? 3'd0 : r_bidx + 3'd1;
        S_DATA_N: if (int'(r_bidx) != ND - 1) r_bidx <= r_bidx + 3'd1;
        S_COMMIT: if (hostctrl_ack) r_bidx <= 3'd0;
        default:  r_bidx <= r_bidx;
      endcase
      // Timeout down-counter reloads on every state change and runs only while waiting on the host.
      if (w_next != r_state) r_tcnt <= TLOAD;
      else if ((r_state == S_ADDR_B || r_state == S_DATA_B || r_state == S_COMMIT) && r_tcnt != 32'd0)
        r_tcnt <= r_tcnt - 32'd1;
    end
  end

endmodule

// File: tb/tb_hostctrl_word_serializer.sv
// Directed bench: four serializer instances (default, MSB-first, timeout, 16/64-bit) share
// inputs; one is selected per test and its outputs checked against hand-computed values.
module tb_hostctrl_word_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, wr_valid = 1'b0, wr_last = 1'b0, ack_data = 1'b0, ack = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [63:0] wr_data = 64'd0;

  logic        hr [4];
  logic        hv [4];
  logic        hn [4];
  logic        hdn [4];
  logic        he [4];
  logic [7:0]  hd [4];
  logic [2:0]  hl [4];
  logic [31:0] hw [4];

  int          sel = 0;
  int          ntests = 0;
  int          nfail = 0;
  int          next_cnt = 0;
  int          first_wait = 0;
  logic [7:0]  q_bytes [$];

  hostctrl_word_serializer u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(hr[0]),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data[31:0]), .wr_last_i(wr_last),
    .hostctrl_data(hd[0]), .hostctrl_valid(hv[0]), .hostctrl_ack_data(ack_data),
    .hostctrl_next(hn[0]), .hostctrl_ack(ack), .hostctrl_done(hdn[0]), .err_o(he[0]),
    .fifo_level_o(hl[0]), .words_sent_o(hw[0]));

  hostctrl_word_serializer #(.MSB_FIRST(1)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(hr[1]),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data[31:0]), .wr_last_i(wr_last),
    .hostctrl_data(hd[1]), .hostctrl_valid(hv[1]), .hostctrl_ack_data(ack_data),
    .hostctrl_next(hn[1]), .hostctrl_ack(ack), .hostctrl_done(hdn[1]), .err_o(he[1]),
    .fifo_level_o(hl[1]), .words_sent_o(hw[1]));

  hostctrl_word_serializer #(.ACK_TIMEOUT(16)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(hr[2]),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data[31:0]), .wr_last_i(wr_last),
    .hostctrl_data(hd[2]), .hostctrl_valid(hv[2]), .hostctrl_ack_data(ack_data),
    .hostctrl_next(hn[2]), .hostctrl_ack(ack), .hostctrl_done(hdn[2]), .err_o(he[2]),
    .fifo_level_o(hl[2]), .words_sent_o(hw[2]));

  hostctrl_word_serializer #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) u3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(hr[3]),
    .wr_addr_i(wr_addr[15:0]), .wr_data_i(wr_data), .wr_last_i(wr_last),
    .hostctrl_data(hd[3]), .hostctrl_valid(hv[3]), .hostctrl_ack_data(ack_data),
    .hostctrl_next(hn[3]), .hostctrl_ack(ack), .hostctrl_done(hdn[3]), .err_o(he[3]),
    .fifo_level_o(hl[3]), .words_sent_o(hw[3]));

  always @(negedge clk) if (hn[sel]) next_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; ack_data = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] d, input logic last);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_last = last;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Host model: takes n bytes, holding off ack_data for one cycle after valid is seen.
  task automatic host_bytes(input int n);
    int k;
    logic [7:0] b0;
    q_bytes.delete();
    for (int b = 0; b < n; b++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!hv[sel] && k < 50);
      if (b == 0) first_wait = k;
      check($sformatf("valid_seen_b%0d", b), hv[sel], 1'b1);
      b0 = hd[sel];
      q_bytes.push_back(b0);
      @(negedge clk);
      check($sformatf("byte_hold_b%0d", b), hd[sel], b0);
      ack_data = 1'b1;
      @(negedge clk);
      ack_data = 1'b0;
      check($sformatf("next_pulse_b%0d", b), {hn[sel], hv[sel]}, 2'b10);
    end
  endtask

  task automatic host_commit();
    @(negedge clk);
    check("commit_quiet", {hv[sel], hn[sel]}, 2'b00);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    logic [7:0] e1 [8] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] e2 [8] = '{8'h00, 8'h00, 8'h00, 8'h40, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] e5 [8] = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    logic [7:0] e6 [10] = '{8'h34, 8'h12, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    int n0;
    int k;

    // Reset state
    sel = 0;
    do_reset();
    check("rst_ready", hr[0], 1'b1);
    check("rst_valid", hv[0], 1'b0);
    check("rst_next", hn[0], 1'b0);
    check("rst_done", hdn[0], 1'b0);
    check("rst_err", he[0], 1'b0);
    check("rst_level", hl[0], 3'd0);
    check("rst_words", hw[0], 32'd0);
    check("rst_data", hd[0], 8'h00);

    // Test 1: default LSB-first word
    n0 = next_cnt;
    push(32'h0000_0040, 64'hDEAD_BEEF, 1'b1);
    check("t1_level_after_push", hl[0], 3'd1);
    check("t1_valid_before_latency", hv[0], 1'b0);
    host_bytes(8);
    check("t1_first_valid_latency", first_wait, 1);
    for (int i = 0; i < 8; i++) check($sformatf("t1_byte%0d", i), q_bytes[i], e1[i]);
    check("t1_done_before_ack", hdn[0], 1'b0);
    host_commit();
    check("t1_next_pulses", next_cnt - n0, 8);
    check("t1_done", hdn[0], 1'b1);
    check("t1_words", hw[0], 32'd1);
    check("t1_ready_in_done", hr[0], 1'b0);
    check("t1_level_empty", hl[0], 3'd0);

    // Test 2: MSB-first
    sel = 1;
    do_reset();
    push(32'h0000_0040, 64'hDEAD_BEEF, 1'b1);
    host_bytes(8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_byte%0d", i), q_bytes[i], e2[i]);
    host_commit();
    check("t2_done", hdn[1], 1'b1);
    check("t2_words", hw[1], 32'd1);

    // Test 3: overflow while host stalls, then drain in push order
    sel = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 32'(32'h10 + i);
      wr_data  = 64'(64'hC0DE_00A0 + i);
      wr_last  = (i == 3);
      @(negedge clk);
      if (i == 3) check("t3_ready_full", hr[0], 1'b0);
    end
    wr_valid = 1'b0;
    check("t3_level_full", hl[0], 3'd4);
    check("t3_ready_still_low", hr[0], 1'b0);
    for (int w = 0; w < 4; w++) begin
      host_bytes(8);
      check($sformatf("t3_w%0d_addr0", w), q_bytes[0], 8'(8'h10 + w));
      check($sformatf("t3_w%0d_data0", w), q_bytes[4], 8'(8'hA0 + w));
      host_commit();
      check($sformatf("t3_w%0d_words", w), hw[0], 32'(w + 1));
      check($sformatf("t3_w%0d_level", w), hl[0], 3'(3 - w));
    end
    check("t3_done", hdn[0], 1'b1);

    // Test 4: ack timeout
    sel = 2;
    do_reset();
    push(32'h0000_0040, 64'hDEAD_BEEF, 1'b1);
    k = 0;
    while (!hv[2] && k < 10) begin @(negedge clk); k++; end
    check("t4_valid_up", hv[2], 1'b1);
    k = 0;
    while (!he[2] && k < 40) begin @(negedge clk); k++; end
    check("t4_err_delay", k, 16);
    check("t4_err", he[2], 1'b1);
    check("t4_valid_low", hv[2], 1'b0);
    check("t4_done_low", hdn[2], 1'b0);
    check("t4_ready_low", hr[2], 1'b0);
    check("t4_words", hw[2], 32'd0);

    // Test 5: reset in the middle of the second word's data phase
    sel = 0;
    do_reset();
    push(32'h0000_0200, 64'h1122_3344, 1'b0);
    push(32'h0000_0300, 64'h5566_7788, 1'b1);
    host_bytes(8);
    host_commit();
    check("t5_words_before", hw[0], 32'd1);
    host_bytes(4);
    @(negedge clk);
    check("t5_in_data_b", hv[0], 1'b1);
    check("t5_data_byte0", hd[0], 8'h88);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", hv[0], 1'b0);
    check("t5_rst_level", hl[0], 3'd0);
    check("t5_rst_words", hw[0], 32'd0);
    check("t5_rst_ready", hr[0], 1'b1);
    check("t5_rst_done", hdn[0], 1'b0);
    push(32'h0000_0044, 64'hCAFE_F00D, 1'b1);
    host_bytes(8);
    for (int i = 0; i < 8; i++) check($sformatf("t5_byte%0d", i), q_bytes[i], e5[i]);
    host_commit();
    check("t5_words_after", hw[0], 32'd1);
    check("t5_done", hdn[0], 1'b1);

    // Test 6: 16-bit address, 64-bit data, three words
    sel = 3;
    do_reset();
    n0 = next_cnt;
    push(32'h0000_1234, 64'h0102_0304_0506_0708, 1'b0);
    push(32'h0000_5678, 64'h1112_1314_1516_1718, 1'b0);
    push(32'h0000_9ABC, 64'h2122_2324_2526_2728, 1'b1);
    host_bytes(10);
    for (int i = 0; i < 10; i++) check($sformatf("t6_w0_byte%0d", i), q_bytes[i], e6[i]);
    host_commit();
    check("t6_w0_done", hdn[3], 1'b0);
    host_bytes(10);
    check("t6_w1_first", q_bytes[0], 8'h78);
    check("t6_w1_last", q_bytes[9], 8'h11);
    host_commit();
    check("t6_w1_done", hdn[3], 1'b0);
    check("t6_w1_words", hw[3], 32'd2);
    host_bytes(10);
    check("t6_w2_first", q_bytes[0], 8'hBC);
    check("t6_w2_last", q_bytes[9], 8'h21);
    host_commit();
    check("t6_next_pulses", next_cnt - n0, 30);
    check("t6_words", hw[3], 32'd3);
    check("t6_done", hdn[3], 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
